// File: rtl/board_pkg.sv
// Shared board geometry, cell encoding and address helper for the board RAM arbiter.
package board_pkg;
  localparam int ROWS         = 8;
  localparam int COLS         = 10;
  localparam int CELL_W       = 3;
  localparam int ADDR_W       = 7;
  localparam int STARVE_LIMIT = 16;
  localparam int ROW_W        = 3;
  localparam int COL_W        = 4;
  localparam int CNT_W        = 5;

  typedef enum logic [CELL_W-1:0] {
    EMPTY   = 3'd0,
    WALL    = 3'd1,
    DIAMOND = 3'd2,
    PLAYER  = 3'd3
  } cell_e;

  typedef enum logic {
    SEL_LOGIC = 1'b0,
    SEL_SPAWN = 1'b1
  } game_sel_e;

  function automatic logic [ADDR_W-1:0] cell_addr(input logic [ROW_W-1:0] row,
                                                  input logic [COL_W-1:0] col,
                                                  input int cols);
    return ADDR_W'(int'(row) * cols + int'(col));
  endfunction
endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter with per-requester starvation counters.
// Grant is combinational; a starved requester wins even while i_hold is high.
module rr_arbiter2
  import board_pkg::*;
#(
  parameter int STARVE_LIMIT = board_pkg::STARVE_LIMIT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] i_req,
  input  logic       i_hold,
  output logic [1:0] o_gnt
);
  logic [CNT_W-1:0] r_cnt [2];
  game_sel_e        r_ptr;
  logic [1:0]       w_starved;

  function automatic logic [1:0] pick(input logic [1:0] cand, input game_sel_e fav);
    if (cand == 2'b11) return (fav == SEL_LOGIC) ? 2'b01 : 2'b10;
    return cand;
  endfunction

  always_comb begin
    for (int k = 0; k < 2; k++)
      w_starved[k] = i_req[k] && (r_cnt[k] == CNT_W'(STARVE_LIMIT));
  end

  // Starved requesters bypass the hold; the pointer still breaks a double starve.
  always_comb begin
    o_gnt = 2'b00;
    if (|w_starved)   o_gnt = pick(w_starved, r_ptr);
    else if (!i_hold) o_gnt = pick(i_req, r_ptr);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt[0] <= '0;
      r_cnt[1] <= '0;
      r_ptr    <= SEL_LOGIC;
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (!i_req[k] || o_gnt[k])                  r_cnt[k] <= '0;
        else if (r_cnt[k] != CNT_W'(STARVE_LIMIT))  r_cnt[k] <= r_cnt[k] + CNT_W'(1);
      end
      if (o_gnt[0])      r_ptr <= SEL_SPAWN;
      else if (o_gnt[1]) r_ptr <= SEL_LOGIC;
    end
  end
endmodule

// File: rtl/board_access_arbiter.sv
// Single-port board RAM arbiter: VGA reads, game-logic reads/writes, spawner writes.
// One access per cycle, 1-cycle read latency, last-write forwarding, out-of-range trap.
module board_access_arbiter
  import board_pkg::*;
#(
  parameter int ROWS         = board_pkg::ROWS,
  parameter int COLS         = board_pkg::COLS,
  parameter int CELL_W       = board_pkg::CELL_W,
  parameter int STARVE_LIMIT = board_pkg::STARVE_LIMIT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              vga_req,
  input  logic [2:0]        vga_row,
  input  logic [3:0]        vga_col,
  output logic [CELL_W-1:0] vga_rdata,
  output logic              vga_valid,
  output logic              vga_miss,
  input  logic              logic_req,
  input  logic              logic_we,
  input  logic [2:0]        logic_row,
  input  logic [3:0]        logic_col,
  input  logic [CELL_W-1:0] logic_wdata,
  output logic              logic_gnt,
  output logic [CELL_W-1:0] logic_rdata,
  output logic              logic_rvalid,
  input  logic              spawn_req,
  input  logic [2:0]        spawn_row,
  input  logic [3:0]        spawn_col,
  input  logic [CELL_W-1:0] spawn_wdata,
  output logic              spawn_gnt,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [CELL_W-1:0] mem_wdata,
  input  logic [CELL_W-1:0] mem_rdata,
  output logic              oob_err
);
  logic [1:0]        w_game_req, w_game_gnt;
  logic              w_vga_gnt, w_any, w_inr, w_we;
  logic [ROW_W-1:0]  w_row;
  logic [COL_W-1:0]  w_col;
  logic [CELL_W-1:0] w_wdata, w_rd_dat;
  logic [ADDR_W-1:0] w_addr;

  logic              r_vga_vld, r_lgc_vld, r_rd_oob, r_fwd_hit, r_wr_vld;
  logic [CELL_W-1:0] r_fwd_dat, r_wr_dat;
  logic [ADDR_W-1:0] r_wr_addr;

  // Nothing is issued while reset is high, so every output is quiet during reset.
  assign w_game_req = {spawn_req, logic_req} & {2{!reset}};

  rr_arbiter2 #(.STARVE_LIMIT(STARVE_LIMIT)) u_rr (
    .clk    (clk),
    .reset  (reset),
    .i_req  (w_game_req),
    .i_hold (vga_req),
    .o_gnt  (w_game_gnt)
  );

  assign w_vga_gnt = vga_req && !reset && !(|w_game_gnt);
  assign w_any     = w_vga_gnt || (|w_game_gnt);

  always_comb begin
    w_row   = vga_row;
    w_col   = vga_col;
    w_we    = 1'b0;
    w_wdata = '0;
    if (w_game_gnt[0]) begin
      w_row   = logic_row;
      w_col   = logic_col;
      w_we    = logic_we;
      w_wdata = logic_wdata;
    end else if (w_game_gnt[1]) begin
      w_row   = spawn_row;
      w_col   = spawn_col;
      w_we    = 1'b1;
      w_wdata = spawn_wdata;
    end
  end

  assign w_inr  = (int'(w_row) < ROWS) && (int'(w_col) < COLS);
  assign w_addr = cell_addr(w_row, w_col, COLS);

  assign logic_gnt = w_game_gnt[0];
  assign spawn_gnt = w_game_gnt[1];
  assign vga_miss  = vga_req && (|w_game_gnt);
  assign mem_en    = w_any && w_inr;
  assign mem_we    = mem_en && w_we;
  assign mem_addr  = w_any ? w_addr : '0;
  assign mem_wdata = mem_we ? w_wdata : '0;
  assign oob_err   = w_any && !w_inr;

  // The RAM may not yet hold last cycle's write, so a read of that cell takes the registered copy.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_vga_vld <= 1'b0;
      r_lgc_vld <= 1'b0;
      r_rd_oob  <= 1'b0;
      r_fwd_hit <= 1'b0;
      r_fwd_dat <= '0;
      r_wr_vld  <= 1'b0;
      r_wr_addr <= '0;
      r_wr_dat  <= '0;
    end else begin
      r_vga_vld <= w_vga_gnt;
      r_lgc_vld <= w_game_gnt[0] && !logic_we;
      r_wr_vld  <= mem_we;
      r_wr_addr <= w_addr;
      r_wr_dat  <= w_wdata;
      if (w_any && !w_we) begin
        r_rd_oob  <= !w_inr;
        r_fwd_hit <= r_wr_vld && (r_wr_addr == w_addr);
        r_fwd_dat <= r_wr_dat;
      end
    end
  end

  assign w_rd_dat     = r_rd_oob ? '0 : (r_fwd_hit ? r_fwd_dat : mem_rdata);
  assign vga_valid    = r_vga_vld;
  assign vga_rdata    = r_vga_vld ? w_rd_dat : '0;
  assign logic_rvalid = r_lgc_vld;
  assign logic_rdata  = r_lgc_vld ? w_rd_dat : '0;
endmodule

// File: tb/tb_board_access_arbiter.sv
// Randomized and directed bench for board_access_arbiter against a cycle-level reference model.
module tb_board_access_arbiter;
  logic       clk = 1'b0;
  logic       reset;
  logic       vga_req, vga_valid, vga_miss;
  logic [2:0] vga_row, vga_rdata;
  logic [3:0] vga_col;
  logic       logic_req, logic_we, logic_gnt, logic_rvalid;
  logic [2:0] logic_row, logic_wdata, logic_rdata;
  logic [3:0] logic_col;
  logic       spawn_req, spawn_gnt;
  logic [2:0] spawn_row, spawn_wdata;
  logic [3:0] spawn_col;
  logic       mem_en, mem_we, oob_err;
  logic [6:0] mem_addr;
  logic [2:0] mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  board_access_arbiter dut (
    .clk(clk), .reset(reset),
    .vga_req(vga_req), .vga_row(vga_row), .vga_col(vga_col),
    .vga_rdata(vga_rdata), .vga_valid(vga_valid), .vga_miss(vga_miss),
    .logic_req(logic_req), .logic_we(logic_we), .logic_row(logic_row), .logic_col(logic_col),
    .logic_wdata(logic_wdata), .logic_gnt(logic_gnt), .logic_rdata(logic_rdata),
    .logic_rvalid(logic_rvalid),
    .spawn_req(spawn_req), .spawn_row(spawn_row), .spawn_col(spawn_col),
    .spawn_wdata(spawn_wdata), .spawn_gnt(spawn_gnt),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .oob_err(oob_err)
  );

  int n_vec = 0, n_err = 0;
  // Reference model state: true board contents, starve counts, favoured game requester (0 logic, 1 spawn).
  int lcnt, scnt, ptr, g_win;
  int board [80];
  int e_vv, e_vd, e_lv, e_ld;
  // Emulated RAM whose writes land one cycle late, so forwarding is observable.
  int ram [128];
  int pend_vld, pend_a, pend_d;
  int o_lg, o_sg, o_vm, o_vv, o_en, o_oob, o_addr, o_lv, o_ld, o_all;

  task automatic chk(input string tag, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    int lst, sst, win, r, c, we, wd, inr, a;
    #2;
    lst = (logic_req && lcnt == 16) ? 1 : 0;
    sst = (spawn_req && scnt == 16) ? 1 : 0;
    if (reset)                      win = 0;
    else if (lst && sst)            win = (ptr == 0) ? 2 : 3;
    else if (lst)                   win = 2;
    else if (sst)                   win = 3;
    else if (vga_req)               win = 1;
    else if (logic_req && spawn_req) win = (ptr == 0) ? 2 : 3;
    else if (logic_req)             win = 2;
    else if (spawn_req)             win = 3;
    else                            win = 0;
    r = vga_row; c = vga_col; we = 0; wd = 0;
    if (win == 2) begin r = logic_row; c = logic_col; we = logic_we; wd = logic_wdata; end
    if (win == 3) begin r = spawn_row; c = spawn_col; we = 1;        wd = spawn_wdata; end
    inr = (r < 8 && c < 10) ? 1 : 0;
    a   = r * 10 + c;

    chk("logic_gnt", logic_gnt, win == 2);
    chk("spawn_gnt", spawn_gnt, win == 3);
    chk("vga_miss", vga_miss, vga_req && win >= 2);
    chk("mem_en", mem_en, win != 0 && inr);
    chk("mem_we", mem_we, win != 0 && inr && we);
    if (win != 0 && inr) chk("mem_addr", mem_addr, a);
    if (win != 0 && inr && we) chk("mem_wdata", mem_wdata, wd);
    chk("oob_err", oob_err, win != 0 && !inr);
    chk("vga_valid", vga_valid, e_vv);
    chk("vga_rdata", vga_rdata, e_vv ? e_vd : 0);
    chk("logic_rvalid", logic_rvalid, e_lv);
    chk("logic_rdata", logic_rdata, e_lv ? e_ld : 0);

    o_lg = logic_gnt; o_sg = spawn_gnt; o_vm = vga_miss; o_vv = vga_valid;
    o_en = mem_en; o_oob = oob_err; o_addr = mem_addr; o_lv = logic_rvalid; o_ld = logic_rdata;
    o_all = |{vga_rdata, vga_valid, vga_miss, logic_gnt, logic_rdata, logic_rvalid, spawn_gnt,
              mem_en, mem_we, mem_addr, mem_wdata, oob_err};

    if (reset) begin
      e_vv = 0; e_lv = 0; lcnt = 0; scnt = 0; ptr = 0;
    end else begin
      e_vv = (win == 1) ? 1 : 0;
      e_lv = (win == 2 && !we) ? 1 : 0;
      e_vd = (win != 0 && !we && inr) ? board[a] : 0;
      e_ld = e_vd;
      if (win != 0 && we && inr) board[a] = wd;
      lcnt = (!logic_req || win == 2) ? 0 : ((lcnt < 16) ? lcnt + 1 : 16);
      scnt = (!spawn_req || win == 3) ? 0 : ((scnt < 16) ? scnt + 1 : 16);
      if (win == 2) ptr = 1;
      if (win == 3) ptr = 0;
    end
    g_win = win;

    if (mem_en && !mem_we) mem_rdata = 3'(ram[mem_addr]);
    else                   mem_rdata = 3'($urandom);
    if (pend_vld != 0) ram[pend_a] = pend_d;
    pend_vld = (mem_en && mem_we) ? 1 : 0;
    pend_a = mem_addr; pend_d = mem_wdata;
    @(negedge clk);
  endtask

  function automatic logic [2:0] rnd_row();
    return ($urandom % 4 == 0) ? 3'($urandom_range(0, 7)) : 3'($urandom_range(0, 1));
  endfunction

  function automatic logic [3:0] rnd_col();
    return ($urandom % 4 == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 2));
  endfunction

  initial begin
    int first_lg;
    reset = 1'b1; mem_rdata = '0;
    vga_req = 0; vga_row = 0; vga_col = 0;
    logic_req = 0; logic_we = 0; logic_row = 0; logic_col = 0; logic_wdata = 0;
    spawn_req = 0; spawn_row = 0; spawn_col = 0; spawn_wdata = 0;
    lcnt = 0; scnt = 0; ptr = 0; g_win = 0;
    e_vv = 0; e_vd = 0; e_lv = 0; e_ld = 0; pend_vld = 0; pend_a = 0; pend_d = 0;
    foreach (board[i]) board[i] = 0;
    foreach (ram[i]) ram[i] = 0;
    @(posedge clk); @(negedge clk);
    tick();
    chk("reset_all_zero", o_all, 0);

    // Both game requesters starve behind continuous VGA traffic.
    reset = 0; vga_req = 1; vga_row = 1; vga_col = 1;
    logic_req = 1; logic_we = 0; logic_row = 1; logic_col = 3;
    spawn_req = 1; spawn_row = 4; spawn_col = 9; spawn_wdata = 5;
    first_lg = 0;
    for (int i = 1; i <= 17; i++) begin
      tick();
      if (o_lg != 0 && first_lg == 0) first_lg = i;
    end
    chk("starve_cycle", first_lg, 17);
    chk("starve_miss", o_vm, 1);
    logic_req = 0;
    tick();
    chk("starve_vga_valid", o_vv, 0);
    chk("starve_spawn_sat", o_sg, 1);
    spawn_req = 0;
    tick(); tick();

    // VGA beats a pending logic read until it drops.
    vga_req = 1; logic_req = 1; logic_we = 0; logic_row = 0; logic_col = 0;
    tick();
    chk("vga_over_logic", o_lg, 0);
    vga_req = 0;
    tick();
    chk("logic_after_vga", o_lg, 1);
    logic_req = 0;

    // Held game requests alternate; pointer now favours spawn.
    logic_req = 1; spawn_req = 1; spawn_row = 3; spawn_col = 3; spawn_wdata = 6;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("rr_alternate", o_lg, i % 2);
    end
    logic_req = 0; spawn_req = 0;
    tick();

    // Read right after a write to the same cell.
    spawn_req = 1; spawn_row = 2; spawn_col = 5; spawn_wdata = 2;
    tick();
    chk("raw_addr", o_addr, 25);
    spawn_req = 0; logic_req = 1; logic_we = 0; logic_row = 2; logic_col = 5;
    tick();
    logic_req = 0;
    tick();
    chk("raw_rvalid", o_lv, 1);
    chk("raw_rdata", o_ld, 2);

    // Column out of range.
    logic_req = 1; logic_we = 0; logic_row = 0; logic_col = 12;
    tick();
    chk("oob_gnt", o_lg, 1);
    chk("oob_pulse", o_oob, 1);
    chk("oob_mem_en", o_en, 0);
    logic_req = 0;
    tick();
    chk("oob_rvalid", o_lv, 1);
    chk("oob_rdata", o_ld, 0);

    // Reset while a logic read is pending behind VGA.
    vga_req = 1; vga_row = 0; vga_col = 1;
    logic_req = 1; logic_we = 0; logic_row = 2; logic_col = 5;
    spawn_req = 1; spawn_row = 1; spawn_col = 1; spawn_wdata = 4;
    tick();
    chk("rst_pending", o_lg, 0);
    reset = 1;
    tick(); tick();
    chk("rst_outputs", o_all, 0);
    chk("rst_no_rvalid", o_lv, 0);
    reset = 0; vga_req = 0;
    tick();
    chk("rst_favours_logic", o_lg, 1);

    for (int n = 0; n < 3000; n++) begin
      if (!logic_req || g_win == 2) begin
        logic_req = 1'($urandom % 2); logic_we = 1'($urandom % 2);
        logic_row = rnd_row(); logic_col = rnd_col(); logic_wdata = 3'($urandom);
      end
      if (!spawn_req || g_win == 3) begin
        spawn_req = ($urandom % 3 == 0) ? 1'b1 : 1'b0;
        spawn_row = rnd_row(); spawn_col = rnd_col(); spawn_wdata = 3'($urandom);
      end
      vga_req = ($urandom % 4 != 0) ? 1'b1 : 1'b0;
      vga_row = rnd_row(); vga_col = rnd_col();
      reset = ($urandom % 128 == 0) ? 1'b1 : 1'b0;
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/board_access_arbiter.md
BOARD_ACCESS_ARBITER -- requirements
Module: board_access_arbiter

Interface
REQ-001 Parameters SHALL be, one per line, name, default, meaning:
  ROWS, 8, board rows
  COLS, 10, board columns
  CELL_W, 3, bits per cell
  STARVE_LIMIT, 16, consecutive denied cycles before a game requester preempts VGA
REQ-002 Ports SHALL be, one per line, name, direction, width, meaning:
  clk  in  1  single clock, all logic on rising edge
  reset  in  1  synchronous, active-high
  vga_req  in  1  VGA read request this cycle
  vga_row  in  3  VGA cell row
  vga_col  in  4  VGA cell column
  vga_rdata  out  CELL_W  VGA read data
  vga_valid  out  1  vga_rdata valid
  vga_miss  out  1  VGA request dropped (preempted)
  logic_req  in  1  game-logic request, held until granted
  logic_we  in  1  1=write, 0=read
  logic_row  in  3  row
  logic_col  in  4  column
  logic_wdata  in  CELL_W  write data
  logic_gnt  out  1  access issued this cycle
  logic_rdata  out  CELL_W  read data
  logic_rvalid  out  1  logic_rdata valid
  spawn_req  in  1  diamond-spawner write request, held until granted
  spawn_row  in  3  row
  spawn_col  in  4  column
  spawn_wdata  in  CELL_W  write data
  spawn_gnt  out  1  write issued this cycle
  mem_en  out  1  board RAM enable
  mem_we  out  1  board RAM write enable
  mem_addr  out  7  flat cell index
  mem_wdata  out  CELL_W  RAM write data
  mem_rdata  in  CELL_W  RAM read data, one cycle after mem_en with mem_we=0
  oob_err  out  1  one-cycle pulse: granted access had col>=COLS or row>=ROWS

Function
REQ-003 At most one RAM access SHALL be issued per cycle; mem_* outputs combinational from the winning request.
REQ-004 mem_addr SHALL equal row*COLS+col, computed in 7 bits (max 79).
REQ-005 Priority SHALL be: starved game requester > vga_req > game requesters (logic/spawn) in round-robin.
REQ-006 Round-robin pointer SHALL move to the other game requester after each game grant; after reset it favours logic.
REQ-007 Per game requester, a 5-bit starve counter SHALL increment each cycle req is high and not granted, clear on grant or req low, and saturate at STARVE_LIMIT.
REQ-008 A requester whose counter equals STARVE_LIMIT SHALL be granted over VGA; if both are starved, the round-robin pointer decides.
REQ-009 When VGA is preempted, vga_miss SHALL pulse in the request cycle and vga_valid SHALL be 0 in the following cycle.
REQ-010 logic_gnt/spawn_gnt SHALL be single-cycle pulses; request fields SHALL be sampled in the gnt cycle; requester may change fields or drop req the next cycle.
REQ-011 Read latency SHALL be exactly one cycle: vga_valid/logic_rvalid high the cycle after the issuing cycle, with rdata = mem_rdata.
REQ-012 Out-of-range access SHALL be granted, SHALL NOT assert mem_en, SHALL pulse oob_err, and reads SHALL return 0 with the valid strobe asserted normally.
REQ-013 Read-after-write: a read issued the cycle after a write to the same address SHALL return the newly written data (forward from a registered last-write).
REQ-014 Requests with req low SHALL never be granted; gnt SHALL never assert with req low.

Reset
REQ-015 On reset all outputs SHALL be 0, starve counters 0, round-robin pointer to logic, forwarding register invalid.
REQ-016 A read issued in the cycle reset is asserted SHALL produce no valid strobe; reset takes effect at the next edge regardless of activity.

Structure
REQ-017 ROWS, COLS, CELL_W, ADDR_W=7, STARVE_LIMIT and the cell enum (EMPTY, WALL, DIAMOND, PLAYER) SHALL reside in shared package board_pkg.
REQ-018 Two-way round-robin with starve counters SHALL be sub-module rr_arbiter2; address calc and forwarding stay in the top.

Verification
REQ-019 VGA and logic read both requesting -> VGA granted; logic_gnt in the cycle VGA drops.
REQ-020 logic and spawn held high, no VGA -> grants alternate logic, spawn, logic, ...
REQ-021 vga_req continuously high, logic_req high -> logic_gnt in cycle 17 after req, vga_miss pulse same cycle, vga_valid 0 next cycle.
REQ-022 spawn write row 2 col 5 data 3'd2, next cycle logic read same cell -> mem_addr 25, logic_rdata 3'd2 with logic_rvalid one cycle later.
REQ-023 logic read col 12 -> logic_gnt, oob_err pulse, mem_en 0, logic_rdata 0 with rvalid next cycle.
REQ-024 reset asserted during a pending logic read -> no logic_rvalid, all outputs 0, next grant favours logic.
